transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/ethpipe_pkg.sv | 16 +
 rtl/tx_req_gen.sv | 16 +
 rtl/transmitter.sv | 143 ++++++++++++++
 tb/tb_transmitter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ethpipe_pkg.sv
// ethpipe_pkg: shared ethpipe codes (TX states, master command words, PHY tags).
package ethpipe_pkg;
    typedef enum logic [3:0] {
        TX_IDLE, TX_HREQ0, TX_HREQ1, TX_HREQ2, TX_HDR,
        TX_DREQ0, TX_DREQ1, TX_DREQ2, TX_DATA, TX_FIN
    } tx_state_t;
    localparam logic [15:0] CMD_HDR = 16'h02ff;
    localparam logic [15:0] CMD_DATA = 16'h10ff;
    localparam logic [1:0] CMD_FLAG = 2'b10;
    localparam logic [1:0] TAG_TWO = 2'b11;
    localparam logic [1:0] TAG_ONE = 2'b10;
    // A one-byte word carries its byte in [15:8], matching the byte order of full words.
    function automatic logic [17:0] phy_word(input logic one, input logic [15:0] d);
        return one ? {TAG_ONE, d[15:8], 8'h00} : {TAG_TWO, d};
    endfunction
endpackage

// File: rtl/tx_req_gen.sv
// tx_req_gen: emits one word of the command/address read request selected by idx.
module tx_req_gen
    import ethpipe_pkg::*;
(
    input  logic        en,
    input  logic [1:0]  idx,
    input  logic [15:0] cmd,
    input  logic [29:0] addr,
    input  logic        full,
    output logic [17:0] din,
    output logic        wr_en
);
    assign din = idx == 2'd0 ? {CMD_FLAG, cmd} :
                 idx == 2'd1 ? {2'b00, addr[29:14]} : {2'b00, addr[13:0], 2'b00};
    assign wr_en = en && !full;
endmodule

// File: rtl/transmitter.sv
// transmitter: DMA ring consumer that fetches frames over the master port and feeds the TX FIFO.
module transmitter
    import ethpipe_pkg::*;
#(
    parameter logic [11:0] MAX_LEN = 12'd1518,
    parameter logic [7:0] BURST_HW = 8'd32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        sys_intr,
    output logic [17:0] phy_din,
    input  logic        phy_full,
    output logic        phy_wr_en,
    output logic [7:0]  phy_tx_count,
    output logic [17:0] mst_din,
    input  logic        mst_full,
    output logic        mst_wr_en,
    input  logic [17:0] mst_dout,
    input  logic        mst_empty,
    output logic        mst_rd_en,
    input  logic [7:0]  dma_status,
    input  logic [19:0] dma_length,
    input  logic [29:0] dma_addr_start,
    input  logic [29:0] dma_addr_wr,
    output logic [29:0] dma_addr_cur
);
    tx_state_t state;
    logic [11:0] len, rem;
    logic [29:0] baddr, ring_end, step, sum, nxt;
    logic [12:0] len7;
    logic [2:0] hpop, hdat;
    logic [7:0] bcnt;
    logic [15:0] hd;
    logic hq, dq, keep_q, last_q, hv, ht, bdone, valid;
    logic hdr_pop, dat_pop, in_ring, req_hdr, req_en, len_ok;
    logic [1:0] req_idx;
    logic unused;

    assign ring_end = dma_addr_start + {10'd0, dma_length};
    assign in_ring = dma_addr_cur >= dma_addr_start && dma_addr_cur < ring_end;
    assign len_ok = len != 12'd0 && len <= MAX_LEN;
    assign len7 = {1'b0, len} + 13'd7;
    assign step = valid ? {19'd0, len7[12:3], 1'b0} : 30'd0;
    assign sum = dma_addr_cur + 30'd2 + step;
    assign nxt = sum >= ring_end ? dma_addr_start : sum;
    assign hdr_pop = state == TX_HDR && !mst_empty && hpop != 3'd4;
    // Bytes past the frame end are drained regardless of PHY backpressure; hv holds a word caught by phy_full.
    assign dat_pop = state == TX_DATA && !mst_empty && !hv && !bdone && bcnt < BURST_HW &&
                     (rem == 12'd0 || !phy_full);
    assign mst_rd_en = hdr_pop || dat_pop;
    assign phy_wr_en = !phy_full && (hv || (dq && keep_q));
    assign phy_din = hv ? phy_word(ht, hd) : phy_word(last_q, mst_dout[15:0]);
    assign req_hdr = state inside {TX_HREQ0, TX_HREQ1, TX_HREQ2};
    assign req_en = req_hdr || state inside {TX_DREQ0, TX_DREQ1, TX_DREQ2};
    assign req_idx = state inside {TX_HREQ0, TX_DREQ0} ? 2'd0 :
                     state inside {TX_HREQ1, TX_DREQ1} ? 2'd1 : 2'd2;
    assign unused = ^{mst_dout[17], dma_status[7:2]};

    tx_req_gen u_req (
        .en(req_en),
        .idx(req_idx),
        .cmd(req_hdr ? CMD_HDR : CMD_DATA),
        .addr(req_hdr ? dma_addr_cur : baddr),
        .full(mst_full),
        .din(mst_din),
        .wr_en(mst_wr_en)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= TX_IDLE;
            dma_addr_cur <= '0;
            phy_tx_count <= '0;
            sys_intr <= 1'b0;
            hq <= 1'b0;
            dq <= 1'b0;
            keep_q <= 1'b0;
            hv <= 1'b0;
        end else begin
            sys_intr <= 1'b0;
            hq <= hdr_pop;
            dq <= dat_pop;
            keep_q <= dat_pop && rem != 12'd0;
            last_q <= rem == 12'd1;
            if (dq && keep_q && phy_full) begin
                hv <= 1'b1;
                hd <= mst_dout[15:0];
                ht <= last_q;
            end else if (hv && !phy_full) hv <= 1'b0;
            case (state)
                TX_IDLE: begin
                    hpop <= '0;
                    hdat <= '0;
                    if (!in_ring) dma_addr_cur <= dma_addr_start;
                    else if (dma_status[0] && dma_addr_cur != dma_addr_wr) state <= TX_HREQ0;
                end
                TX_HREQ0: if (!mst_full) state <= TX_HREQ1;
                TX_HREQ1: if (!mst_full) state <= TX_HREQ2;
                TX_HREQ2: if (!mst_full) state <= TX_HDR;
                TX_HDR: begin
                    hpop <= hpop + {2'b00, hdr_pop};
                    if (hq) begin
                        hdat <= hdat + 3'd1;
                        if (hdat == 3'd0) len <= {mst_dout[3:0], mst_dout[15:8]};
                        if (hdat == 3'd3) begin
                            valid <= len_ok;
                            rem <= len;
                            baddr <= dma_addr_cur + 30'd2;
                            state <= len_ok ? TX_DREQ0 : TX_FIN;
                        end
                    end
                end
                TX_DREQ0: if (!mst_full) state <= TX_DREQ1;
                TX_DREQ1: if (!mst_full) state <= TX_DREQ2;
                TX_DREQ2: if (!mst_full) begin
                    state <= TX_DATA;
                    bcnt <= '0;
                    bdone <= 1'b0;
                end
                TX_DATA: begin
                    if (dat_pop) begin
                        bcnt <= bcnt + 8'd1;
                        rem <= rem > 12'd1 ? rem - 12'd2 : 12'd0;
                    end
                    if (dq && mst_dout[16]) bdone <= 1'b1;
                    if (bdone && !hv) begin
                        state <= rem != 12'd0 ? TX_DREQ0 : TX_FIN;
                        if (rem != 12'd0) baddr <= baddr + 30'd16;
                    end
                end
                TX_FIN: begin
                    dma_addr_cur <= nxt;
                    if (valid) begin
                        phy_tx_count <= phy_tx_count + 8'd1;
                        sys_intr <= dma_status[1];
                    end
                    state <= TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: directed frame table plus hand sequences against a host-memory/master model.
module tb_transmitter;
    logic sys_clk = 1'b0;
    logic sys_rst, sys_intr, phy_full, phy_wr_en, mst_full, mst_wr_en, mst_empty, mst_rd_en;
    logic [17:0] phy_din, mst_din, mst_dout;
    logic [7:0] phy_tx_count, dma_status;
    logic [19:0] dma_length;
    logic [29:0] dma_addr_start, dma_addr_wr, dma_addr_cur;

    transmitter dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_intr(sys_intr),
        .phy_din(phy_din), .phy_full(phy_full), .phy_wr_en(phy_wr_en), .phy_tx_count(phy_tx_count),
        .mst_din(mst_din), .mst_full(mst_full), .mst_wr_en(mst_wr_en),
        .mst_dout(mst_dout), .mst_empty(mst_empty), .mst_rd_en(mst_rd_en),
        .dma_status(dma_status), .dma_length(dma_length), .dma_addr_start(dma_addr_start),
        .dma_addr_wr(dma_addr_wr), .dma_addr_cur(dma_addr_cur)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] ptr;
        logic [11:0] len;
        logic ie;
        logic mode;
        int words;
        int odd;
        int bursts;
        int bytes;
        logic [31:0] cur;
        int cnt;
        int intr;
    } vec_t;
    vec_t vecs[9];

    int errors = 0, checks = 0;
    logic [7:0] hdr [int unsigned];
    logic [17:0] q[$];
    int wc = 0, words, odd, bursts, intr_cnt, wfull, bad, rx_idx;
    logic [31:0] exp_base;
    logic [15:0] cmd, hi;
    logic mode = 1'b0;
    logic s_rd = 0, s_wr = 0, s_full = 0, s_pwr = 0, s_pfull = 0, s_intr = 0;
    logic [17:0] s_din = '0, s_pdin = '0;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return hdr.exists(a) ? hdr[a] : a[7:0] ^ a[15:8] ^ 8'h3c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        if (b !== byte_at(exp_base + 32'(rx_idx))) bad++;
        rx_idx++;
    endtask

    // Host memory + master FIFO model; strobes sampled after the negedge take effect at the next negedge.
    initial begin
        mst_empty = 1'b1;
        mst_full = 1'b0;
        phy_full = 1'b0;
        mst_dout = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                q.delete();
                wc = 0;
            end else begin
                if (s_rd) begin
                    if (q.size() > 0) mst_dout = q.pop_front();
                    else bad++;
                end
                if (s_wr) begin
                    if (s_full) wfull++;
                    if (wc == 0) begin
                        if (!s_din[17]) bad++;
                        cmd = s_din[15:0];
                    end else if (wc == 1) hi = s_din[15:0];
                    else begin
                        int n;
                        logic [31:0] a;
                        n = cmd == 16'h10ff ? 32 : 4;
                        if (cmd == 16'h10ff) bursts++;
                        for (int k = 0; k < n; k++) begin
                            a = {hi, s_din[15:0]} + 32'(2 * k);
                            q.push_back({1'b0, k == n - 1, byte_at(a), byte_at(a + 1)});
                        end
                    end
                    wc = wc == 2 ? 0 : wc + 1;
                end
                if (s_pwr) begin
                    if (s_pfull) wfull++;
                    words++;
                    if (s_pdin[17:16] == 2'b11) begin
                        rx_byte(s_pdin[15:8]);
                        rx_byte(s_pdin[7:0]);
                    end else if (s_pdin[17:16] == 2'b10) begin
                        odd++;
                        rx_byte(s_pdin[15:8]);
                    end else bad++;
                end
                if (s_intr) intr_cnt++;
            end
            mst_empty = q.size() == 0;
            phy_full = mode ? ($urandom_range(0, 2) == 0) : 1'b0;
            mst_full = mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            s_rd = mst_rd_en;
            s_wr = mst_wr_en;
            s_din = mst_din;
            s_full = mst_full;
            s_pwr = phy_wr_en;
            s_pdin = phy_din;
            s_pfull = phy_full;
            s_intr = sys_intr;
        end
    end

    task automatic setup(input logic [31:0] ptr, input logic [11:0] len, input logic [31:0] wr);
        hdr.delete();
        hdr[ptr] = len[7:0];
        hdr[ptr + 1] = {4'h0, len[11:8]};
        exp_base = ptr + 8;
        rx_idx = 0;
        bad = 0;
        words = 0;
        odd = 0;
        bursts = 0;
        intr_cnt = 0;
        wfull = 0;
        dma_addr_wr = wr[31:2];
    endtask

    task automatic wait_cur(input logic [31:0] target, input string name);
        int n = 0;
        while (dma_addr_cur !== target[31:2] && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        chk(name, 32'(n < 20000), 32'd1);
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1;
        dma_status = '0;
        dma_length = '0;
        dma_addr_start = '0;
        dma_addr_wr = '0;
        vecs[0] = '{32'h1000, 12'd60,   1'b1, 1'b0, 30,  0, 1,  60,   32'h1048, 1, 1};
        vecs[1] = '{32'h1048, 12'd61,   1'b1, 1'b0, 31,  1, 1,  61,   32'h1090, 2, 1};
        vecs[2] = '{32'h1090, 12'd0,    1'b1, 1'b0, 0,   0, 0,  0,    32'h1098, 2, 0};
        vecs[3] = '{32'h1098, 12'd2000, 1'b1, 1'b0, 0,   0, 0,  0,    32'h10A0, 2, 0};
        vecs[4] = '{32'h10A0, 12'd1518, 1'b1, 1'b0, 759, 0, 24, 1518, 32'h1698, 3, 1};
        vecs[5] = '{32'h1698, 12'd1518, 1'b0, 1'b0, 759, 0, 24, 1518, 32'h1C90, 4, 0};
        vecs[6] = '{32'h1C90, 12'd1,    1'b1, 1'b1, 1,   1, 1,  1,    32'h1CA0, 5, 1};
        vecs[7] = '{32'h1CA0, 12'd100,  1'b1, 1'b1, 50,  0, 2,  100,  32'h1D10, 6, 1};
        vecs[8] = '{32'h1D10, 12'd743,  1'b1, 1'b1, 372, 1, 12, 743,  32'h1000, 7, 1};
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_cur", 32'(dma_addr_cur), 32'd0);
        chk("rst_cnt", 32'(phy_tx_count), 32'd0);
        chk("rst_intr", 32'(sys_intr), 32'd0);
        chk("rst_strobes", {29'd0, phy_wr_en, mst_wr_en, mst_rd_en}, 32'd0);
        dma_length = 20'h400;
        dma_addr_start = 30'h400;
        dma_addr_wr = 30'h400;
        dma_status = 8'h01;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reload", 32'(dma_addr_cur), 32'h400);
        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            dma_status = {6'd0, vecs[i].ie, 1'b1};
            setup(vecs[i].ptr, vecs[i].len, vecs[i].cur);
            wait_cur(vecs[i].cur, $sformatf("v%0d_timeout", i));
            mode = 1'b0;
            chk($sformatf("v%0d_cur", i), {dma_addr_cur, 2'b00}, vecs[i].cur);
            chk($sformatf("v%0d_words", i), 32'(words), 32'(vecs[i].words));
            chk($sformatf("v%0d_odd", i), 32'(odd), 32'(vecs[i].odd));
            chk($sformatf("v%0d_bursts", i), 32'(bursts), 32'(vecs[i].bursts));
            chk($sformatf("v%0d_bytes", i), 32'(rx_idx), 32'(vecs[i].bytes));
            chk($sformatf("v%0d_bad", i), 32'(bad), 32'd0);
            chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'd0);
            chk($sformatf("v%0d_cnt", i), 32'(phy_tx_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_intr", i), 32'(intr_cnt), 32'(vecs[i].intr));
        end
        // Clearing the enable mid-frame must let the frame finish.
        dma_status = 8'h03;
        setup(32'h1000, 12'd200, 32'h10D0);
        repeat (40) @(negedge sys_clk);
        dma_status = 8'h00;
        wait_cur(32'h10D0, "nostop_timeout");
        chk("nostop_cnt", 32'(phy_tx_count), 32'd8);
        chk("nostop_bytes", 32'(rx_idx), 32'd200);
        chk("nostop_bad", 32'(bad), 32'd0);
        chk("nostop_intr", 32'(intr_cnt), 32'd0);
        setup(32'h10D0, 12'd10, 32'h10E8);
        repeat (300) @(negedge sys_clk);
        chk("blocked_cur", 32'(dma_addr_cur), 32'h434);
        chk("blocked_words", 32'(words), 32'd0);
        dma_status = 8'h03;
        wait_cur(32'h10E8, "resume_timeout");
        chk("resume_cnt", 32'(phy_tx_count), 32'd9);
        chk("resume_words", 32'(words), 32'd5);
        chk("resume_bytes", 32'(rx_idx), 32'd10);
        chk("resume_intr", 32'(intr_cnt), 32'd1);
        // Reset in the middle of a frame drops it.
        dma_status = 8'h01;
        setup(32'h10E8, 12'd300, 32'h1200);
        repeat (30) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;
        chk("midrst_cnt", 32'(phy_tx_count), 32'd0);
        chk("midrst_cur", 32'(dma_addr_cur), 32'd0);
        chk("midrst_strobes", {29'd0, phy_wr_en, mst_wr_en, mst_rd_en}, 32'd0);
        dma_status = 8'h00;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("midrst_reload", 32'(dma_addr_cur), 32'h400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
